// File: rtl/cbus_arbiter_rr_pkg.sv
// Shared cached-bus types and arbiter state encoding.
// Future crossbars reuse the state enum and the index-width helper.
package cbus_arbiter_rr_pkg;

    typedef struct packed {
        logic        valid;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } cbus_req_t;

    typedef struct packed {
        logic        valid;
        logic        last;
        logic [31:0] rdata;
    } cbus_resp_t;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    // A grant index needs at least one bit, even when there is a single master.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cbus_arbiter_rr_pick.sv
// Combinational rotating search: first set bit of valid scanning start, start+1, ... mod N.
// Fixed priority is obtained by tying start to zero.
module cbus_arbiter_rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     valid,
    input  logic [IDX_W-1:0] start,
    output logic             found,
    output logic [IDX_W-1:0] winner
);

    logic [IDX_W-1:0] idx;

    // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = 0; k < N; k++) begin
            idx = IDX_W'((int'(start) + k) % N);
            if (!found && valid[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/cbus_arbiter_rr.sv
// N-to-1 cached-bus arbiter: fixed or round-robin policy, optional same-cycle issue,
// grant held for a whole burst and released on oresp.last.
module cbus_arbiter_rr
    import cbus_arbiter_rr_pkg::*;
#(
    parameter int  NUM_INPUTS  = 2,
    parameter int  ROUND_ROBIN = 1,
    parameter int  FAST_ISSUE  = 1,
    localparam int IDX_W       = idx_width(NUM_INPUTS)
) (
    input  logic             clk,
    input  logic             reset,
    input  cbus_req_t        ireqs  [NUM_INPUTS],
    output cbus_resp_t       iresps [NUM_INPUTS],
    output cbus_req_t        oreq,
    input  cbus_resp_t       oresp,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_index
);

    arb_state_e            state;
    logic [IDX_W-1:0]      index;
    logic [IDX_W-1:0]      rr_ptr;
    cbus_req_t             saved_req;

    logic [NUM_INPUTS-1:0] valid_vec;
    logic [IDX_W-1:0]      pick_start;
    logic                  found;
    logic [IDX_W-1:0]      winner;

    always_comb begin
        valid_vec = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            valid_vec[i] = ireqs[i].valid;
        end
    end

    assign pick_start = (ROUND_ROBIN != 0) ? rr_ptr : '0;

    cbus_arbiter_rr_pick #(
        .N     (NUM_INPUTS),
        .IDX_W (IDX_W)
    ) u_pick (
        .valid  (valid_vec),
        .start  (pick_start),
        .found  (found),
        .winner (winner)
    );

    // Priority after a release starts just past the releasing master.
    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
        return (i == IDX_W'(NUM_INPUTS - 1)) ? '0 : i + 1'b1;
    endfunction

    // NOTE: state registers use non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ARB_IDLE;
            index     <= '0;
            rr_ptr    <= '0;
            saved_req <= '0;
        end else begin
            unique case (state)
                ARB_IDLE: begin
                    if (found) begin
                        if ((FAST_ISSUE != 0) && oresp.last) begin
                            if (ROUND_ROBIN != 0) rr_ptr <= wrap_inc(winner);
                        end else begin
                            state     <= ARB_BUSY;
                            index     <= winner;
                            saved_req <= ireqs[winner];
                        end
                    end
                end
                ARB_BUSY: begin
                    if (oresp.last) begin
                        state     <= ARB_IDLE;
                        saved_req <= '0;
                        if (ROUND_ROBIN != 0) rr_ptr <= wrap_inc(index);
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    // Outputs are forced quiet while reset is low, even before the first reset edge.
    always_comb begin
        oreq        = '0;
        grant_valid = 1'b0;
        grant_index = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            iresps[i] = '0;
        end
        if (reset) begin
            if (state == ARB_BUSY) begin
                oreq          = saved_req;
                iresps[index] = oresp;
                grant_valid   = 1'b1;
                grant_index   = index;
            end else if ((FAST_ISSUE != 0) && found) begin
                oreq           = ireqs[winner];
                iresps[winner] = oresp;
                grant_valid    = 1'b1;
                grant_index    = winner;
            end
        end
    end

endmodule

// File: tb/tb_cbus_arbiter_rr.sv
// Randomized scoreboard bench for cbus_arbiter_rr across several policy/issue configurations.
// A transaction-level model predicts grants and routed beats; a monitor compares DUT outputs.
module tb_cbus_arbiter_rr;
    import cbus_arbiter_rr_pkg::*;

    localparam int NCFG   = 5;
    localparam int CYCLES = 2000;

    typedef struct {
        int        idx;
        cbus_req_t req;
        int        due;
    } grant_t;

    typedef struct {
        int         idx;
        cbus_resp_t resp;
        int         due;
    } beat_t;

    logic clk = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   done_count = 0;

    always #5 clk = ~clk;

    task automatic check_vec(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // First requesting master met when scanning start, start+1, ... around the ring.
    function automatic int pick(input bit [7:0] v, input int n, input int start);
        for (int k = 0; k < n; k++) begin
            if (v[(start + k) % n]) return (start + k) % n;
        end
        return -1;
    endfunction

    function automatic cbus_req_t rand_req(input bit valid);
        cbus_req_t r;
        r.valid = valid;
        r.we    = 1'($urandom_range(0, 1));
        r.addr  = $urandom;
        r.wdata = $urandom;
        return r;
    endfunction

    for (genvar c = 0; c < NCFG; c++) begin : g_cfg
        localparam int N    = (c == 4) ? 1 : 3;
        localparam int RR   = (c == 1 || c == 3) ? 0 : 1;
        localparam int FAST = (c == 1 || c == 2) ? 0 : 1;
        localparam int IW   = (N > 1) ? $clog2(N) : 1;

        logic       reset = 1'b0;
        cbus_req_t  ireqs  [N];
        cbus_resp_t iresps [N];
        cbus_req_t  oreq;
        cbus_resp_t oresp;
        logic       grant_valid;
        logic [IW-1:0] grant_index;

        grant_t exp_q[$];
        beat_t  beat_q[$];
        int     cyc  = 0;
        bit     stop = 1'b0;

        cbus_arbiter_rr #(
            .NUM_INPUTS  (N),
            .ROUND_ROBIN (RR),
            .FAST_ISSUE  (FAST)
        ) u_dut (
            .clk         (clk),
            .reset       (reset),
            .ireqs       (ireqs),
            .iresps      (iresps),
            .oreq        (oreq),
            .oresp       (oresp),
            .grant_valid (grant_valid),
            .grant_index (grant_index)
        );

        // Stimulus plus reference model: masters, memory side and the expected grant/beat stream.
        initial begin : stim
            int     owner;
            int     ptr;
            int     beats_left;
            int     w;
            int     act;
            int     req_pct;
            bit     want [N];
            int     gap  [N];
            bit [7:0] v;
            bit     route;
            bit     rst_now;

            owner = -1;
            ptr = 0;
            beats_left = 0;
            for (int i = 0; i < N; i++) begin
                want[i]  = 1'b0;
                gap[i]   = 0;
                ireqs[i] = '0;
            end
            oresp = '0;

            for (int t = 0; t < CYCLES; t++) begin
                @(posedge clk);
                #1;
                cyc++;
                rst_now = (t < 3) || (t > 20 && $urandom_range(0, 299) == 0);
                reset   = !rst_now;
                req_pct = (t < 700) ? 100 : (t < 1400) ? 50 : 20;

                for (int i = 0; i < N; i++) begin
                    if (!want[i]) begin
                        if (gap[i] > 0) begin
                            gap[i]--;
                            ireqs[i] = rand_req(1'b0);
                        end else if ($urandom_range(0, 99) < req_pct) begin
                            want[i]  = 1'b1;
                            ireqs[i] = rand_req(1'b1);
                        end else begin
                            ireqs[i] = rand_req(1'b0);
                        end
                    end else if (i == owner) begin
                        // Owner misbehaving mid-burst must not disturb the captured request.
                        if ($urandom_range(0, 7) == 0) ireqs[i] = rand_req(1'($urandom_range(0, 1)));
                    end else if ($urandom_range(0, 3) == 0) begin
                        ireqs[i] = rand_req(1'b1);
                    end
                end

                oresp.valid = 1'b0;
                oresp.last  = 1'b0;
                oresp.rdata = $urandom;
                route = 1'b0;
                act   = -1;

                if (rst_now) begin
                    if (owner >= 0) want[owner] = 1'b0;
                    owner = -1;
                    ptr = 0;
                    beats_left = 0;
                    exp_q.delete();
                end else begin
                    if (owner < 0) begin
                        v = '0;
                        for (int i = 0; i < N; i++) v[i] = ireqs[i].valid;
                        w = pick(v, N, (RR != 0) ? ptr : 0);
                        if (w >= 0) begin
                            exp_q.push_back('{w, ireqs[w], (FAST != 0) ? cyc : cyc + 1});
                            beats_left = ($urandom_range(0, 2) == 0) ? 1 : $urandom_range(1, 8);
                            if (FAST != 0) begin
                                route = 1'b1;
                                act   = w;
                            end else begin
                                owner = w;
                            end
                        end
                    end else begin
                        route = 1'b1;
                        act   = owner;
                    end

                    if (route) begin
                        if ($urandom_range(0, 9) < 7) begin
                            oresp.valid = 1'b1;
                            beats_left--;
                            oresp.last = (beats_left == 0);
                            beat_q.push_back('{act, oresp, cyc});
                        end
                        if (oresp.last) begin
                            if (RR != 0) ptr = (act + 1) % N;
                            owner     = -1;
                            want[act] = 1'b0;
                            gap[act]  = $urandom_range(0, 2);
                        end else begin
                            owner = act;
                        end
                    end else if ($urandom_range(0, 9) == 0) begin
                        // A stray last with nobody owning the bus must be ignored.
                        oresp.valid = 1'($urandom_range(0, 1));
                        oresp.last  = 1'b1;
                    end
                end
            end

            @(posedge clk);
            #1;
            stop = 1'b1;
            @(negedge clk);
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[$].due > cyc) exp_q.pop_back();
            check_int($sformatf("c%0d grants drained", c), exp_q.size(), 0);
            check_int($sformatf("c%0d beats drained", c), beat_q.size(), 0);
            done_count++;
        end

        // Monitor: pops expectations whenever the DUT starts a grant or routes a beat.
        initial begin : mon
            bit     prev_gv;
            bit     prev_last;
            bit     have_cur;
            bit     start;
            grant_t cur;
            beat_t  b;

            prev_gv   = 1'b0;
            prev_last = 1'b0;
            have_cur  = 1'b0;
            forever begin
                @(negedge clk);
                if (stop) break;
                if (cyc == 0) continue;

                start = grant_valid && (!prev_gv || prev_last);
                if (start) begin
                    if (exp_q.size() == 0) begin
                        check_int($sformatf("c%0d unexpected grant", c), int'(grant_valid), 0);
                    end else begin
                        cur = exp_q.pop_front();
                        have_cur = 1'b1;
                        check_int($sformatf("c%0d grant cycle", c), cyc, cur.due);
                        check_int($sformatf("c%0d grant index", c), int'(grant_index), cur.idx);
                    end
                end
                while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                    check_int($sformatf("c%0d missing grant", c), cyc, exp_q[0].due);
                    void'(exp_q.pop_front());
                end

                if (grant_valid) begin
                    if (have_cur) check_vec($sformatf("c%0d oreq", c), 128'(oreq), 128'(cur.req));
                end else begin
                    check_vec($sformatf("c%0d idle oreq", c), 128'(oreq), '0);
                    check_int($sformatf("c%0d idle grant_index", c), int'(grant_index), 0);
                end

                for (int i = 0; i < N; i++) begin
                    if (iresps[i].valid) begin
                        if (beat_q.size() == 0) begin
                            check_int($sformatf("c%0d unexpected beat", c), i, -1);
                        end else begin
                            b = beat_q.pop_front();
                            check_int($sformatf("c%0d beat owner", c), i, b.idx);
                            check_vec($sformatf("c%0d beat data", c), 128'(iresps[i]), 128'(b.resp));
                            check_int($sformatf("c%0d beat cycle", c), cyc, b.due);
                        end
                    end else if (!grant_valid || i != int'(grant_index)) begin
                        check_vec($sformatf("c%0d non-owner iresp", c), 128'(iresps[i]), '0);
                    end
                end
                while (beat_q.size() > 0 && beat_q[0].due <= cyc) begin
                    check_int($sformatf("c%0d missing beat", c), beat_q[0].idx, -1);
                    void'(beat_q.pop_front());
                end

                prev_gv   = grant_valid;
                prev_last = grant_valid && iresps[grant_index].last;
            end
        end
    end

    initial begin
        for (int k = 0; k < CYCLES + 100; k++) begin
            @(posedge clk);
            if (done_count == NCFG) break;
        end
        check_int("all configs finished", done_count, NCFG);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
